alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 16-bit combinational ALU in the CPU datapath.
- Keeps the same 4-bit opcode map and flag set (c, z, n, o).
- Adds generic WIDTH, variable-amount shifts/rotates, carry-in add, and an optional iterative multiply.
- Uses a valid/ready handshake on both sides so the controller can stall; sits between the register-file read stage and write-back.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 4 and a power of two.
- SW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, operation request.
- in_ready, output, 1, block can accept (high only in IDLE and when reset is low).
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B; b[SW-1:0] is the shift/rotate amount.
- op, input, 4, operation selector.
- cin, input, 1, carry flag in, used by ADDC/ROR/ROL.
- out_valid, output, 1, result and flags valid.
- out_ready, input, 1, consumer takes result.
- r, output, WIDTH, result.
- c, output, 1, carry flag.
- z, output, 1, zero flag.
- n, output, 1, negative flag.
- o, output, 1, overflow flag.

Behaviour:
- Opcodes:
  - 0000 ADD a+b.
  - 0001 SUB a+~b+1; c=carry out (1 means no borrow).
  - 0010 ADDC a+b+cin.
  - 0011 AND.
  - 0100 OR.
  - 0101 XOR.
  - 0110 NOT a.
  - 0111 NEG, i.e. ~a+1.
  - 1000 ROR: rotate the (WIDTH+1)-bit ring {c,a} right by k = b[SW-1:0], with c initialised from cin.
  - 1001 ROL: same ring, rotated left.
  - 1010 SHR: logical right shift by k.
  - 1011 SHL: logical left shift by k.
  - 1100 MUL (optional feature).
  - All others: undefined.
- Flags:
  - o is signed overflow for ADD/SUB/ADDC; o=0 for all other ops.
  - c is carry out for ADD/SUB/ADDC; c=0 for logic ops and NEG.
  - c is the last bit shifted out for SHR/SHL. If k=0: c=0 for shifts, c=cin for rotates.
  - n=r[WIDTH-1] and z=(r==0) for every op, including undefined ops.
  - Undefined op: r=0, c=0, o=0, n=0, z=1, latency as a single-cycle op.
- States: IDLE, SHIFT, MUL, DONE.
- IDLE:
  - in_ready=1.
  - Accept on the edge where in_valid&&in_ready (edge T).
  - Single-cycle ops, and shifts/rotates with k=0: compute, register r/flags, go to DONE. out_valid is high after edge T.
  - Shift/rotate with k>0: load working reg, cnt=k, go to SHIFT.
  - MUL: go to MUL with cnt=WIDTH.
- SHIFT: one bit step per edge, cnt decrements; on the step where cnt==1, register the final r/flags and go to DONE. out_valid is high after edge T+k.
- MUL: one shift-add step per edge for WIDTH edges, then DONE. out_valid is high after edge T+WIDTH.
- DONE:
  - out_valid=1, in_ready=0.
  - r and flags are held stable until out_ready is sampled high, then IDLE.
  - No same-cycle accept out of DONE.
- Operand and op inputs are sampled only at accept; changes afterwards are ignored.
- in_valid while not ready is ignored; it is not queued.
- Reset:
  - state=IDLE, out_valid=0, r=0, c=z=n=o=0, counters 0.
  - in_ready=0 while reset is high.
  - Reset mid-SHIFT/MUL/DONE aborts the operation; no result is ever presented.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: op 1100 is an unsigned WIDTH×WIDTH multiply.
  - r = low WIDTH bits of the product.
  - c=1 iff the high WIDTH bits are nonzero.
  - o=0; n/z from r.
  - Latency WIDTH edges in the MUL state.
- Undefined: the MUL state and datapath are not built; 1100 behaves as an undefined op (r=0, z=1, single-cycle).

Test Plan:
- WIDTH=16, ADD a=0x7FFF b=0x0001, out_ready=1 -> after 1 edge out_valid=1, r=0x8000, n=1, o=1, c=0, z=0; in_ready back to 1 the following cycle.
- SUB a=0x0005 b=0x0005 -> r=0x0000, z=1, c=1, o=0, n=0. ADDC a=0xFFFF b=0x0000 cin=1 -> r=0x0000, c=1, z=1.
- ROR a=0x0001 b=1 cin=0 -> out_valid after 2 edges, r=0x0000, c=1, z=1. SHL a=0x1001 b=4 -> out_valid after 5 edges, r=0x0010, c=1.
- Backpressure: ADD done with out_ready=0 for 10 cycles, toggling a/b/in_valid meanwhile -> r/flags constant, in_ready=0, no new accept; one accept follows the out_ready handshake.
- Reset at the 3rd step of SHR a=0xFFFF b=15 -> out_valid never rises, all outputs 0, in_ready=1 on the first cycle after reset deasserts; next ADD 1+1 returns r=0x0002.
- MUL 0x0100×0x0100:
  - ALU_SEQ_MUL_EN defined -> after 17 edges, r=0x0000, c=1, z=1.
  - Not defined -> after 1 edge, r=0, z=1, c=0.
  - 0x00FF×0x0003 (macro defined) -> r=0x02FD, c=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle valid/ready ALU; shifts and rotates step one bit per cycle.
// Defining ALU_SEQ_MUL_EN adds an iterative shift-add unsigned multiply on op 1100.
module alu_seq #(
    parameter int WIDTH = 16,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             c,
    output logic             z,
    output logic             n,
    output logic             o
);
    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
    state_t r_state, w_next;
    logic [SW:0] r_cnt;
    logic [WIDTH-1:0] r_work, r_res;
    logic [1:0] r_sh;
    logic r_cf, r_c, r_z, r_n, r_o;
    logic w_accept, w_is_sh, w_is_mul, w_last, w_fill, w_sh_cf, w_c1, w_o1, w_fin_c, w_fin_o;
    logic [SW-1:0] w_k;
    logic [WIDTH-1:0] w_bb, w_r1, w_sh_work, w_fin_r;
    logic [WIDTH:0] w_sum;
    assign in_ready = r_state == IDLE && !reset;
    assign out_valid = r_state == DONE;
    assign {r, c, z, n, o} = {r_res, r_c, r_z, r_n, r_o};
    assign w_k = b[SW-1:0];
    assign w_accept = in_valid && in_ready;
    assign w_is_sh = op[3:2] == 2'b10 && w_k != '0;
    assign w_last = r_cnt == (SW+1)'(1);
`ifdef ALU_SEQ_MUL_EN
    assign w_is_mul = op == 4'b1100;
`else
    assign w_is_mul = 1'b0;
`endif
    assign w_bb = op == 4'b0001 ? ~b : b;
    assign w_sum = {1'b0, a} + {1'b0, w_bb} + (WIDTH+1)'(op == 4'b0001 || (op == 4'b0010 && cin));
    // Rotates feed the ring bit back in; logical shifts feed zero.
    assign w_fill = ~r_sh[1] & r_cf;
    assign w_sh_work = r_sh[0] ? {r_work[WIDTH-2:0], w_fill} : {w_fill, r_work[WIDTH-1:1]};
    assign w_sh_cf = r_sh[0] ? r_work[WIDTH-1] : r_work[0];
    always_comb begin
        w_r1 = '0;
        w_c1 = 1'b0;
        w_o1 = 1'b0;
        case (op)
            4'b0000, 4'b0001, 4'b0010: begin
                w_r1 = w_sum[WIDTH-1:0];
                w_c1 = w_sum[WIDTH];
                w_o1 = a[WIDTH-1] == w_bb[WIDTH-1] && w_sum[WIDTH-1] != a[WIDTH-1];
            end
            4'b0011: w_r1 = a & b;
            4'b0100: w_r1 = a | b;
            4'b0101: w_r1 = a ^ b;
            4'b0110: w_r1 = ~a;
            4'b0111: w_r1 = ~a + 1'b1;
            4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                w_r1 = a;
                w_c1 = ~op[1] & cin;
            end
            default: ;
        endcase
    end
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] r_hi, r_mcand;
    logic [WIDTH:0] w_msum;
    assign w_msum = {1'b0, r_hi} + (r_work[0] ? {1'b0, r_mcand} : '0);
`endif
    always_comb begin
        w_fin_r = w_r1;
        w_fin_c = w_c1;
        w_fin_o = w_o1;
        if (r_state == SHIFT) begin
            w_fin_r = w_sh_work;
            w_fin_c = w_sh_cf;
            w_fin_o = 1'b0;
        end
`ifdef ALU_SEQ_MUL_EN
        if (r_state == MUL) begin
            w_fin_r = {w_msum[0], r_work[WIDTH-1:1]};
            w_fin_c = |w_msum[WIDTH:1];
            w_fin_o = 1'b0;
        end
`endif
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_is_sh ? SHIFT : w_is_mul ? MUL : DONE;
            SHIFT, MUL: if (w_last) w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_work <= '0;
            r_sh <= '0;
            r_cf <= 1'b0;
            r_res <= '0;
            {r_c, r_z, r_n, r_o} <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_hi <= '0;
            r_mcand <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_cnt <= w_is_mul ? (SW+1)'(WIDTH) : {1'b0, w_k};
                r_work <= w_is_mul ? b : a;
                r_sh <= op[1:0];
                r_cf <= cin;
`ifdef ALU_SEQ_MUL_EN
                r_hi <= '0;
                r_mcand <= a;
`endif
            end else if (r_state == SHIFT) begin
                r_cnt <= r_cnt - 1'b1;
                r_work <= w_sh_work;
                r_cf <= w_sh_cf;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (r_state == MUL) begin
                r_cnt <= r_cnt - 1'b1;
                {r_hi, r_work} <= {w_msum, r_work[WIDTH-1:1]};
            end
`endif
            if (w_next == DONE && r_state != DONE) begin
                r_res <= w_fin_r;
                r_c <= w_fin_c;
                r_z <= w_fin_r == '0;
                r_n <= w_fin_r[WIDTH-1];
                r_o <= w_fin_o;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; arithmetic reference model, decoupled monitor.
module tb_alu_seq;
    localparam int W = 16;
    localparam int SW = 4;
    typedef struct {
        logic [W-1:0] r;
        logic c, z, n, o;
        int lat;
        int acc;
    } exp_t;
    logic clk = 0, reset = 1, in_valid = 0, out_ready = 1, cin = 0;
    logic in_ready, out_valid, c, z, n, o;
    logic [W-1:0] a = 0, b = 0, r;
    logic [3:0] op = 0;
    int cyc = 0, checks = 0, errors = 0;
    logic rand_ordy = 0, ordy_val = 1, mon_ov = 0, mon_hs = 0;
    exp_t q[$];
    exp_t cur;
    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .c(c), .z(z), .n(n), .o(o)
    );
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rand_ordy ? ($urandom_range(0, 3) != 0) : ordy_val;
    end
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic exp_t model(logic [3:0] f, logic [W-1:0] x, logic [W-1:0] y, logic ci);
        exp_t e;
        longint m = longint'(1) << W;
        longint ux = x, uy = y, sx = $signed(x), sy = $signed(y), u = 0, s = 0, v = 0;
        int k = int'(y[SW-1:0]);
        e = '{default: 0};
        v = (ci ? m : 0) + ux;
        case (f)
            0: begin u = ux + uy; s = sx + sy; end
            1: begin u = ux + (m - 1 - uy) + 1; s = sx - sy; end
            2: begin u = ux + uy + ci; s = sx + sy + ci; end
            3: e.r = x & y;
            4: e.r = x | y;
            5: e.r = x ^ y;
            6: e.r = ~x;
            7: e.r = W'((m - ux) % m);
            8: v = ((v >> k) | (v << (W + 1 - k))) % (2 * m);
            9: v = ((v << k) | (v >> (W + 1 - k))) % (2 * m);
            10: begin e.r = W'(ux >> k); e.c = k != 0 && ((ux >> (k - 1)) & 1) != 0; end
            11: begin e.r = W'((ux << k) % m); e.c = k != 0 && ((ux >> (W - k)) & 1) != 0; end
`ifdef ALU_SEQ_MUL_EN
            12: begin u = ux * uy; e.r = W'(u % m); e.c = u >= m; e.lat = W; end
`endif
            default: ;
        endcase
        if (f <= 2) begin
            e.r = W'(u % m);
            e.c = u >= m;
            e.o = s >= m / 2 || s < -(m / 2);
        end
        if (f == 8 || f == 9) begin
            e.r = W'(v % m);
            e.c = v >= m;
        end
        if (f >= 8 && f <= 11) e.lat = k;
        e.z = e.r == 0;
        e.n = e.r[W-1];
        return e;
    endfunction
    task automatic send(logic [3:0] f, logic [W-1:0] x, logic [W-1:0] y, logic ci);
        exp_t e;
        int t = 0;
        while (!in_ready && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
            return;
        end
        op = f; a = x; b = y; cin = ci; in_valid = 1;
        e = model(f, x, y, ci);
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 0;
        op = 4'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask
    task automatic wait_idle();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (q.size() != 0 || out_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d expected 0", q.size());
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (reset) begin
            mon_ov = 0;
            mon_hs = 0;
        end else begin
            if (mon_hs) chk("in_ready_after_handshake", in_ready, 1);
            if (out_valid && !mon_ov) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got r=%0h expected no result", r);
                end else begin
                    cur = q.pop_front();
                    chk("latency", cyc - cur.acc, cur.lat);
                end
            end
            if (out_valid) begin
                chk("r", r, cur.r);
                chk("c", c, cur.c);
                chk("z", z, cur.z);
                chk("n", n, cur.n);
                chk("o", o, cur.o);
                chk("in_ready_busy", in_ready, 0);
            end
            mon_hs = out_valid && out_ready;
            mon_ov = out_valid;
        end
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_r", r, 0);
        chk("rst_flags", {c, z, n, o}, 0);
        reset = 0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;
        send(4'h0, 16'h7FFF, 16'h0001, 0);
        send(4'h1, 16'h0005, 16'h0005, 0);
        send(4'h2, 16'hFFFF, 16'h0000, 1);
        send(4'h8, 16'h0001, 16'h0001, 0);
        send(4'hB, 16'h1001, 16'h0004, 0);
        send(4'hC, 16'h0100, 16'h0100, 0);
        send(4'hC, 16'h00FF, 16'h0003, 0);
        send(4'h9, 16'h8000, 16'h0000, 1);
        send(4'h7, 16'h8000, 16'h1234, 0);
        wait_idle();
        ordy_val = 0;
        send(4'h0, 16'h1234, 16'h4321, 0);
        repeat (10) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); op = 4'($urandom);
        end
        in_valid = 0;
        ordy_val = 1;
        send(4'h0, 16'h0F0F, 16'h00F1, 1);
        send(4'hA, 16'hFFFF, 16'h000F, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1;
        q.delete();
        @(posedge clk);
        #1;
        chk("in_ready_in_reset", in_ready, 0);
        chk("out_valid_in_reset", out_valid, 0);
        reset = 0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_r", r, 0);
        chk("abort_flags", {c, z, n, o}, 0);
        @(posedge clk);
        #1;
        send(4'h0, 16'h0001, 16'h0001, 0);
        rand_ordy = 1;
        repeat (300) send(4'($urandom), W'($urandom), W'($urandom), 1'($urandom));
        rand_ordy = 0;
        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
